// File: rtl/irq_controller.sv
// Vectored interrupt controller: synchronizes raw source lines, latches pending
// events, arbitrates lowest-index unmasked source and runs a REQ/SERVICE handshake.
module irq_controller #(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irqIn,
    input  logic [31:0]      inputAddr,
    input  logic [31:0]      inputData,
    input  logic             wrEn,
    input  logic [31:0]      outputAddr,
    output logic [31:0]      outputData,
    input  logic             irqAck,
    output logic             irqReq,
    output logic [4:0]       irqId
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [31:0] OFF_PENDING = 32'd0;
    localparam logic [31:0] OFF_MASK    = 32'd1;
    localparam logic [31:0] OFF_EDGE    = 32'd2;
    localparam logic [31:0] OFF_ACTIVE  = 32'd3;
    localparam logic [31:0] OFF_EOI     = 32'd4;
    localparam logic [31:0] OFF_RAW     = 32'd5;

    logic [N_SRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    state_e           state_q, state_d;
    logic             irq_req_q, irq_req_d;
    logic [4:0]       irq_id_q, irq_id_d;
    logic [31:0]      out_data_q, out_data_d;

    logic [31:0]      wr_off_s, rd_off_s;
    logic             wr_pending_s, wr_mask_s, wr_edge_s, wr_eoi_s;
    logic             take_ack_s, eoi_match_s, unused_s;
    logic [N_SRC-1:0] armed_s, rise_s, clr_s, id_onehot_s;
    logic [4:0]       lowest_s;

    assign wr_off_s = inputAddr - BASE_ADDR;
    assign rd_off_s = outputAddr - BASE_ADDR;
    assign unused_s = ^inputData;

    // Write decode, arbitration winner and one-hot of the latched id
    always_comb begin
        wr_pending_s = wrEn && (wr_off_s == OFF_PENDING);
        wr_mask_s    = wrEn && (wr_off_s == OFF_MASK);
        wr_edge_s    = wrEn && (wr_off_s == OFF_EDGE);
        wr_eoi_s     = wrEn && (wr_off_s == OFF_EOI);
        take_ack_s   = (state_q == ST_REQ) && irqAck;
        eoi_match_s  = wr_eoi_s && (inputData[4:0] == irq_id_q);
        armed_s      = pending_q & mask_q;
        rise_s       = sync2_q & ~sync3_q;
        lowest_s     = 5'd0;
        id_onehot_s  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            lowest_s       = armed_s[i] ? 5'(i) : lowest_s;
            id_onehot_s[i] = (5'(i) == irq_id_q);
        end
    end

    // Register next-state: a new rising edge beats any clear on the same bit
    always_comb begin
        clr_s = wr_pending_s ? inputData[N_SRC-1:0] : '0;
        if (take_ack_s) begin
            clr_s = clr_s | id_onehot_s;
        end else begin
            clr_s = clr_s;
        end
        pending_d = (edge_q & ((pending_q & ~clr_s) | rise_s)) | (~edge_q & sync2_q);
        mask_d    = wr_mask_s ? inputData[N_SRC-1:0] : mask_q;
        edge_d    = wr_edge_s ? inputData[N_SRC-1:0] : edge_q;
    end

    // Request/service state machine
    always_comb begin
        state_d   = state_q;
        irq_req_d = irq_req_q;
        irq_id_d  = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|armed_s) begin
                    state_d   = ST_REQ;
                    irq_req_d = 1'b1;
                    irq_id_d  = lowest_s;
                end else begin
                    state_d   = ST_IDLE;
                    irq_req_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (take_ack_s) begin
                    state_d   = ST_SERVICE;
                    irq_req_d = 1'b0;
                end else if (~|(armed_s & id_onehot_s)) begin
                    state_d   = ST_IDLE;
                    irq_req_d = 1'b0;
                end else begin
                    state_d   = ST_REQ;
                    irq_req_d = 1'b1;
                end
            end
            ST_SERVICE: begin
                irq_req_d = 1'b0;
                if (eoi_match_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    // Read mux, registered one cycle later
    always_comb begin
        case (rd_off_s)
            OFF_PENDING: out_data_d = 32'(pending_q);
            OFF_MASK:    out_data_d = 32'(mask_q);
            OFF_EDGE:    out_data_d = 32'(edge_q);
            OFF_ACTIVE:  out_data_d = {(state_q == ST_SERVICE), 26'd0, irq_id_q};
            OFF_RAW:     out_data_d = 32'(sync2_q);
            default:     out_data_d = 32'd0;
        endcase
    end

    // All state flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            state_q    <= ST_IDLE;
            irq_req_q  <= 1'b0;
            irq_id_q   <= 5'd0;
            out_data_q <= 32'd0;
        end else begin
            sync1_q    <= irqIn;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            state_q    <= state_d;
            irq_req_q  <= irq_req_d;
            irq_id_q   <= irq_id_d;
            out_data_q <= out_data_d;
        end
    end

    assign outputData = out_data_q;
    assign irqReq     = irq_req_q;
    assign irqId      = irq_id_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized checks of irq_controller against a transaction-level
// model: serviced ids come out in ascending order of (sources & mask).
module tb_irq_controller;
    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h0000_4000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irqIn = '0;
    logic [31:0]   inputAddr = 32'd0;
    logic [31:0]   inputData = 32'd0;
    logic          wrEn = 1'b0;
    logic [31:0]   outputAddr = 32'd0;
    logic [31:0]   outputData;
    logic          irqAck = 1'b0;
    logic          irqReq;
    logic [4:0]    irqId;

    int total = 0;
    int bad   = 0;

    irq_controller #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .irqIn(irqIn),
        .inputAddr(inputAddr), .inputData(inputData), .wrEn(wrEn),
        .outputAddr(outputAddr), .outputData(outputData),
        .irqAck(irqAck), .irqReq(irqReq), .irqId(irqId)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_addr(input logic [31:0] addr, input logic [31:0] d);
        inputAddr = addr;
        inputData = d;
        wrEn      = 1'b1;
        step(1);
        wrEn      = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        wr_addr(BASE + 32'(off), d);
    endtask

    task automatic chk_addr(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        outputAddr = addr;
        step(1);
        chk(tag, outputData, exp);
    endtask

    task automatic chk_reg(input string tag, input int off, input logic [31:0] exp);
        chk_addr(tag, BASE + 32'(off), exp);
    endtask

    task automatic ack();
        irqAck = 1'b1;
        step(1);
        irqAck = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] s);
        irqIn = s;
        step(1);
        irqIn = '0;
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    initial begin
        logic [N-1:0] m, s, act, pend;
        int id;

        // reset state before any clock edge
        #1;
        chk("rst_req", 32'(irqReq), 32'd0);
        chk("rst_id", 32'(irqId), 32'd0);
        chk("rst_data", outputData, 32'd0);
        step(2);
        rst = 1'b1;
        chk_reg("rst_active", 3, 32'd0);
        chk_reg("rst_mask", 1, 32'd0);

        // edge source 2: latency, ack, ACTIVE, EOI
        wr(2, 32'hFF);
        wr(1, 32'h04);
        pulse(8'h04);
        step(2);
        chk("lat3_req", 32'(irqReq), 32'd0);
        step(1);
        chk("lat4_req", 32'(irqReq), 32'd1);
        chk("lat4_id", 32'(irqId), 32'd2);
        ack();
        chk("svc_req", 32'(irqReq), 32'd0);
        chk_reg("svc_pending", 0, 32'd0);
        chk_reg("svc_active", 3, 32'h8000_0002);
        ack();
        chk_reg("svc_ack_ignored", 3, 32'h8000_0002);
        wr(4, 32'd3);
        chk_reg("eoi_mismatch", 3, 32'h8000_0002);
        wr(4, 32'd2);
        chk_reg("eoi_match", 3, 32'h0000_0002);
        chk("idle_req", 32'(irqReq), 32'd0);

        // priority: sources 1 and 5
        wr(1, 32'h22);
        pulse(8'h22);
        step(3);
        chk("prio_req1", 32'(irqReq), 32'd1);
        chk("prio_id1", 32'(irqId), 32'd1);
        ack();
        wr(4, 32'd1);
        step(1);
        chk("prio_req5", 32'(irqReq), 32'd1);
        chk("prio_id5", 32'(irqId), 32'd5);
        ack();
        chk_reg("prio_pending", 0, 32'd0);
        wr(4, 32'd5);
        step(1);
        chk("prio_done", 32'(irqReq), 32'd0);

        // level source 0
        wr(2, 32'h00);
        wr(1, 32'h01);
        irqIn = 8'h01;
        step(4);
        chk("lvl_req", 32'(irqReq), 32'd1);
        chk("lvl_id", 32'(irqId), 32'd0);
        wr(0, 32'h01);
        chk_reg("lvl_w1c_noeffect", 0, 32'h01);
        chk("lvl_req_hold", 32'(irqReq), 32'd1);
        irqIn = 8'h00;
        step(4);
        chk("lvl_drop_req", 32'(irqReq), 32'd0);
        chk_reg("lvl_drop_active", 3, 32'd0);
        chk_reg("lvl_drop_pending", 0, 32'd0);

        // collision: W1C lands on the cycle the synchronized edge arrives
        wr(1, 32'h00);
        wr(2, 32'hFF);
        irqIn = 8'h08;
        step(1);
        irqIn = 8'h00;
        step(1);
        wr(0, 32'h08);
        chk_reg("coll_pending", 0, 32'h08);
        chk("coll_masked_req", 32'(irqReq), 32'd0);
        ack();
        chk_reg("coll_ack_idle", 0, 32'h08);
        wr(0, 32'h08);
        chk_reg("coll_w1c", 0, 32'h00);

        // register window
        chk_addr("win_above", BASE + 32'd6, 32'd0);
        chk_addr("win_below", BASE - 32'd1, 32'd0);
        wr(1, 32'hFFFF_FFFF);
        chk_reg("mask_pad", 1, 32'h0000_00FF);
        wr_addr(BASE + 32'd6, 32'd0);
        wr_addr(BASE + 32'd9, 32'd0);
        chk_reg("mask_oob_write", 1, 32'h0000_00FF);
        chk_reg("edge_pad", 2, 32'h0000_00FF);
        wr(1, 32'h00);
        irqIn = 8'h81;
        step(2);
        chk_reg("raw", 5, 32'h81);
        irqIn = 8'h00;
        step(3);
        wr(0, 32'hFF);
        chk_reg("raw_cleanup", 0, 32'd0);

        // randomized edge events against the ordered-service model
        for (int it = 0; it < 24; it++) begin
            m = N'($urandom);
            s = N'($urandom);
            wr(1, 32'(m));
            pulse(s);
            step(3);
            act  = s & m;
            pend = s;
            while (act != '0) begin
                id = lowest(act);
                chk("rnd_req", 32'(irqReq), 32'd1);
                chk("rnd_id", 32'(irqId), 32'(id));
                ack();
                pend[id] = 1'b0;
                chk_reg("rnd_pending", 0, 32'(pend));
                chk_reg("rnd_active", 3, 32'h8000_0000 | 32'(id));
                wr(4, 32'(id));
                act[id] = 1'b0;
                step(1);
            end
            chk("rnd_idle", 32'(irqReq), 32'd0);
            chk_reg("rnd_left", 0, 32'(s & ~m));
            wr(0, 32'hFF);
        end

        // reset while in SERVICE
        wr(1, 32'h10);
        wr(2, 32'hFF);
        pulse(8'h30);
        step(3);
        chk("pre_rst_req", 32'(irqReq), 32'd1);
        chk("pre_rst_id", 32'(irqId), 32'd4);
        ack();
        chk_reg("pre_rst_active", 3, 32'h8000_0004);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req", 32'(irqReq), 32'd0);
        chk("async_id", 32'(irqId), 32'd0);
        chk("async_data", outputData, 32'd0);
        step(2);
        rst = 1'b1;
        chk_reg("post_pending", 0, 32'd0);
        chk_reg("post_mask", 1, 32'd0);
        chk_reg("post_edge", 2, 32'd0);
        chk_reg("post_active", 3, 32'd0);

        // no request until MASK is written nonzero
        irqIn = 8'hFF;
        step(6);
        chk("nomask_req", 32'(irqReq), 32'd0);
        chk_reg("nomask_pending", 0, 32'hFF);
        wr(1, 32'h01);
        step(1);
        chk("mask_req", 32'(irqReq), 32'd1);
        chk("mask_id", 32'(irqId), 32'd0);
        irqIn = 8'h00;
        step(4);
        chk("mask_drop", 32'(irqReq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources (legal 1..31).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h00004000, first word address of the register window.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port irqIn, input, N_SRC, raw asynchronous source lines (e.g. UART status bits).
REQ-006 SHALL have port inputAddr, input, 32, CPU write address.
REQ-007 SHALL have port inputData, input, 32, CPU write data.
REQ-008 SHALL have port wrEn, input, 1, CPU write strobe.
REQ-009 SHALL have port outputAddr, input, 32, CPU read address.
REQ-010 SHALL have port outputData, output, 32, registered read data.
REQ-011 SHALL have port irqAck, input, 1, single-cycle CPU acceptance pulse.
REQ-012 SHALL have port irqReq, output, 1, interrupt request to flow controller.
REQ-013 SHALL have port irqId, output, 5, index of the requested/in-service source.

Function
REQ-014 SHALL pass each irqIn bit through a 2-flop synchronizer before any use.
REQ-015 SHALL decode register offsets (address minus BASE_ADDR): 0 PENDING (R, write-1-to-clear), 1 MASK (RW), 2 EDGE (RW, 1=rising-edge, 0=level), 3 ACTIVE (R), 4 EOI (W), 5 RAW (R, synchronized lines).
REQ-016 SHALL ignore writes outside offsets 0..5 and writes to read-only offsets.
REQ-017 SHALL return read data one cycle after outputAddr is presented; outputData SHALL be 0 when the address is outside the window.
REQ-018 SHALL read bits [31:N_SRC] of PENDING, MASK, EDGE, RAW as 0.
REQ-019 Edge-mode source: SHALL set pending bit on a synchronized 0->1 transition; bit stays set until W1C or irqAck for that id.
REQ-020 Level-mode source: pending bit SHALL equal the synchronized level each cycle; W1C and irqAck have no effect on it.
REQ-021 Pending bits SHALL latch regardless of MASK; MASK only gates arbitration.
REQ-022 Simultaneous new edge and W1C/irqAck clear on same bit: set SHALL win.
REQ-023 SHALL implement FSM states IDLE, REQ, SERVICE.
REQ-024 IDLE: when (PENDING & MASK) != 0, SHALL latch lowest-index such source into irqId and go to REQ next cycle.
REQ-025 REQ: irqReq SHALL be 1; irqId SHALL be stable; on irqAck go to SERVICE and clear that id's pending bit if edge-mode.
REQ-026 REQ: if the latched source's pending or mask bit drops before irqAck, SHALL return to IDLE and deassert irqReq next cycle.
REQ-027 SERVICE: irqReq SHALL be 0; new pending events SHALL latch but not request.
REQ-028 SERVICE: a write to EOI whose data[4:0] equals irqId SHALL return to IDLE; non-matching EOI SHALL be ignored.
REQ-029 irqAck outside REQ SHALL be ignored.
REQ-030 ACTIVE read SHALL return {bit31 = (state==SERVICE), bits[4:0] = irqId, others 0}.
REQ-031 Minimum latency source edge at pin to irqReq=1 SHALL be 4 cycles (2 sync, 1 pending, 1 arbitrate).

Reset
REQ-032 On rst=0, SHALL asynchronously clear synchronizers, PENDING, MASK, EDGE, FSM (to IDLE), irqReq, irqId, outputData to 0.
REQ-033 Reset mid-REQ or mid-SERVICE SHALL abandon the interrupt; no pending state survives.
REQ-034 After rst release, SHALL not request until MASK is written nonzero.

Verification
REQ-035 Edge: EDGE=0xFF, MASK=0x04, pulse irqIn[2] -> irqReq=1, irqId=2 four cycles later; irqAck -> PENDING bit2=0, ACTIVE=0x80000002; EOI write 2 -> IDLE.
REQ-036 Priority: sources 1 and 5 pending, both unmasked -> irqId=1; after EOI 1 -> irqId=5 requested.
REQ-037 Level: EDGE=0, MASK=0x01, hold irqIn[0]=1 -> irqReq=1; drop irqIn[0] before ack -> irqReq=0 within 4 cycles, FSM IDLE.
REQ-038 Collision: W1C PENDING bit3 in same cycle as synchronized edge on source 3 -> PENDING bit3 reads 1.
REQ-039 Window: read BASE_ADDR+6 and BASE_ADDR-1 -> outputData=0; write MASK=0xFFFFFFFF with N_SRC=8 -> MASK reads 0x000000FF.
REQ-040 Reset: assert rst in SERVICE -> irqReq=0, ACTIVE=0, PENDING=0, MASK=0 immediately, no clock needed.
